// File: rtl/alu_sequencer.sv
// alu_sequencer: three-state instruction sequencer for the 8-bit ALU.
// Holds a 4-entry register file, issues operands/opcodes to an external
// combinational ALU, and writes back the result and status flags.
// Optional feature macro: STICKY_OVF_EN (sticky overflow flag + CLRV opcode).
module alu_sequencer #(
    parameter int unsigned          DATA_W  = 8,
    parameter logic [DATA_W-1:0]    REG_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_v,
    output logic              flag_sv,
    output logic              done,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int unsigned NUM_REGS = 4;
    localparam logic [3:0]  OP_SUB   = 4'h1;
    localparam logic [3:0]  OP_LDI   = 4'h8;
    localparam logic [3:0]  OP_MOV   = 4'h9;
    localparam logic [3:0]  OP_CMP   = 4'hA;
    localparam logic [3:0]  OP_CLRV  = 4'hB;
    localparam logic [3:0]  OP_NONE  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_op;
    logic [1:0]        r_rd;
    logic [1:0]        r_rs;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_ready;
    logic              r_done;
    logic [3:0]        r_alu_op;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic              r_z;
    logic              r_c;
    logic              r_v;
    logic              r_sv;

    logic              w_accept;
    logic [3:0]        w_opc;
    logic [1:0]        w_rd;
    logic [1:0]        w_rs;
    logic [3:0]        w_issue_op;

    assign w_accept = instr_valid && r_ready;
    assign w_opc    = instr[15:12];
    assign w_rd     = instr[11:10];
    assign w_rs     = instr[9:8];

    // ALU opcode issued for an incoming instruction (CMP reuses SUB)
    always_comb begin
        w_issue_op = OP_NONE;
        if (!w_opc[3]) begin
            w_issue_op = w_opc;
        end else if (w_opc == OP_CMP) begin
            w_issue_op = OP_SUB;
        end
    end

    // Sequencer FSM, register file, flags and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= OP_NONE;
            r_rd     <= 2'd0;
            r_rs     <= 2'd0;
            r_imm    <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_alu_op <= OP_NONE;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_sv     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= REG_RST;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_opc;
                        r_rd     <= w_rd;
                        r_rs     <= w_rs;
                        r_imm    <= DATA_W'(instr[7:0]);
                        r_alu_op <= w_issue_op;
                        r_alu_a  <= r_regs[w_rd];
                        r_alu_b  <= r_regs[w_rs];
                        r_ready  <= 1'b0;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // writeback and flag capture at the end of the execute cycle
                    if (!r_op[3] || (r_op == OP_CMP)) begin
                        if (!r_op[3]) begin
                            r_regs[r_rd] <= alu_result;
                        end
                        r_z <= alu_zero;
                        r_c <= alu_carry;
                        r_v <= alu_overflow;
`ifdef STICKY_OVF_EN
                        if (alu_overflow) begin
                            r_sv <= 1'b1;
                        end
`endif
                    end else if (r_op == OP_LDI) begin
                        r_regs[r_rd] <= r_imm;
                        r_z          <= (r_imm == '0);
                    end else if (r_op == OP_MOV) begin
                        r_regs[r_rd] <= r_regs[r_rs];
                    end else if (r_op == OP_CLRV) begin
`ifdef STICKY_OVF_EN
                        r_sv <= 1'b0;
`endif
                    end
                    r_alu_op <= OP_NONE;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done   <= 1'b0;
                    r_ready  <= 1'b1;
                    r_alu_op <= OP_NONE;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign done        = r_done;
    assign alu_op      = r_alu_op;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign flag_z      = r_z;
    assign flag_c      = r_c;
    assign flag_v      = r_v;
`ifdef STICKY_OVF_EN
    assign flag_sv     = r_sv;
`else
    assign flag_sv     = 1'b0;
`endif
    assign dbg_data    = r_regs[dbg_sel];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural 8-bit ALU.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_overflow;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;
    logic        flag_sv;
    logic        done;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;

`ifdef STICKY_OVF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    alu_sequencer #(.DATA_W(8), .REG_RST(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .flag_sv(flag_sv),
        .done(done), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: carry is carry-out for add/inc, borrow for sub/dec
    logic [8:0] t;
    always_comb begin
        t            = 9'd0;
        alu_overflow = 1'b0;
        case (alu_op)
            4'h0: begin t = {1'b0, alu_a} + {1'b0, alu_b};
                        alu_overflow = (alu_a[7] == alu_b[7]) && (t[7] != alu_a[7]); end
            4'h1: begin t = {1'b0, alu_a} - {1'b0, alu_b};
                        alu_overflow = (alu_a[7] != alu_b[7]) && (t[7] != alu_a[7]); end
            4'h2: t = {1'b0, alu_a & alu_b};
            4'h3: t = {1'b0, alu_a | alu_b};
            4'h4: t = {1'b0, alu_a ^ alu_b};
            4'h5: t = {1'b0, ~alu_a};
            4'h6: begin t = {1'b0, alu_a} + 9'd1; alu_overflow = (alu_a == 8'h7F); end
            4'h7: begin t = {1'b0, alu_a} - 9'd1; alu_overflow = (alu_a == 8'h80); end
            default: t = 9'd0;
        endcase
        alu_result = t[7:0];
        alu_carry  = t[8];
        alu_zero   = (t[7:0] == 8'h00);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [3:0] exp_op(input logic [3:0] opc);
        if (opc < 4'h8) return opc;
        if (opc == 4'hA) return 4'h1;
        return 4'hF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [1:0] idx, input logic [7:0] exp, input string tag);
        dbg_sel = idx;
        #1;
        chk(tag, 32'(dbg_data), 32'(exp));
    endtask

    task automatic chk_flags(input logic z, input logic c, input logic v,
                             input logic sv, input string tag);
        chk({tag, ".Z"},  32'(flag_z),  32'(z));
        chk({tag, ".C"},  32'(flag_c),  32'(c));
        chk({tag, ".V"},  32'(flag_v),  32'(v));
        chk({tag, ".SV"}, 32'(flag_sv), 32'(sv));
    endtask

    // Issue one instruction from a negedge in IDLE and check the 3-cycle handshake
    task automatic run_instr(input logic [15:0] ins, input bit chk_ab,
                             input logic [7:0] ea, input logic [7:0] eb, input string tag);
        int n = 0;
        instr_valid = 1'b1;
        instr       = ins;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".ready_before"}, 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        chk({tag, ".exec_ready"}, 32'(instr_ready), 32'd0);
        chk({tag, ".exec_done"},  32'(done),        32'd0);
        chk({tag, ".exec_op"},    32'(alu_op),      32'(exp_op(ins[15:12])));
        if (chk_ab) begin
            chk({tag, ".alu_a"}, 32'(alu_a), 32'(ea));
            chk({tag, ".alu_b"}, 32'(alu_b), 32'(eb));
        end
        @(negedge clk);
        chk({tag, ".done_hi"},    32'(done),        32'd1);
        chk({tag, ".done_ready"}, 32'(instr_ready), 32'd0);
        chk({tag, ".done_op"},    32'(alu_op),      32'hF);
        @(negedge clk);
        chk({tag, ".idle_done"},  32'(done),        32'd0);
        chk({tag, ".idle_ready"}, 32'(instr_ready), 32'd1);
    endtask

    logic [15:0] bb [4];
    int          idx, last, dones, since;
    logic        acc;

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_sel     = 2'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.ready", 32'(instr_ready), 32'd1);
        chk("rst.done",  32'(done),        32'd0);
        chk("rst.op",    32'(alu_op),      32'hF);
        chk("rst.a",     32'(alu_a),       32'd0);
        chk("rst.b",     32'(alu_b),       32'd0);
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0, "rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted during EXEC discards the instruction
        instr_valid = 1'b1;
        instr       = mk(4'h8, 2'd1, 2'd0, 8'hAA);
        @(negedge clk);
        chk("midrst.in_exec", 32'(instr_ready), 32'd0);
        instr_valid = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk("midrst.ready", 32'(instr_ready), 32'd1);
        chk("midrst.done",  32'(done),        32'd0);
        chk("midrst.op",    32'(alu_op),      32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst.no_done", 32'(done), 32'd0);
        end
        for (int i = 0; i < 4; i++) chk_reg(2'(i), 8'h00, "midrst.reg");

        // 7F + 01: signed overflow, no carry
        run_instr(mk(4'h8, 2'd0, 2'd0, 8'h7F), 1'b0, 8'h00, 8'h00, "ldi_r0");
        run_instr(mk(4'h8, 2'd1, 2'd0, 8'h01), 1'b0, 8'h00, 8'h00, "ldi_r1");
        run_instr(mk(4'h0, 2'd0, 2'd1, 8'h00), 1'b1, 8'h7F, 8'h01, "add_r0r1");
        chk_reg(2'd0, 8'h80, "add1.r0");
        chk_reg(2'd1, 8'h01, "add1.r1");
        chk_flags(1'b0, 1'b0, 1'b1, STICKY, "add1");

        // FF + 01: wraps to zero with carry; LDI leaves C/V alone
        run_instr(mk(4'h8, 2'd2, 2'd0, 8'hFF), 1'b0, 8'h00, 8'h00, "ldi_r2");
        run_instr(mk(4'h8, 2'd3, 2'd0, 8'h01), 1'b0, 8'h00, 8'h00, "ldi_r3");
        chk_flags(1'b0, 1'b0, 1'b1, STICKY, "ldi_keeps_cv");
        run_instr(mk(4'h0, 2'd2, 2'd3, 8'h00), 1'b1, 8'hFF, 8'h01, "add_r2r3");
        chk_reg(2'd2, 8'h00, "add2.r2");
        chk_flags(1'b1, 1'b1, 1'b0, STICKY, "add2");

        // CMP, XOR with rd==rs, MOV, LDI zero, NOP
        run_instr(mk(4'h8, 2'd0, 2'd0, 8'h05), 1'b0, 8'h00, 8'h00, "ldi_r0_5");
        chk_flags(1'b0, 1'b1, 1'b0, STICKY, "ldi5");
        run_instr(mk(4'hA, 2'd0, 2'd0, 8'h00), 1'b1, 8'h05, 8'h05, "cmp_r0r0");
        chk_reg(2'd0, 8'h05, "cmp.r0");
        chk_flags(1'b1, 1'b0, 1'b0, STICKY, "cmp");
        run_instr(mk(4'h4, 2'd1, 2'd1, 8'h00), 1'b1, 8'h01, 8'h01, "xor_r1r1");
        chk_reg(2'd1, 8'h00, "xor.r1");
        chk_flags(1'b1, 1'b0, 1'b0, STICKY, "xor");
        run_instr(mk(4'h9, 2'd3, 2'd0, 8'h00), 1'b0, 8'h00, 8'h00, "mov_r3r0");
        chk_reg(2'd3, 8'h05, "mov.r3");
        chk_flags(1'b1, 1'b0, 1'b0, STICKY, "mov");
        run_instr(mk(4'h8, 2'd0, 2'd0, 8'h11), 1'b0, 8'h00, 8'h00, "ldi_r0_11");
        run_instr(mk(4'h8, 2'd2, 2'd0, 8'h00), 1'b0, 8'h00, 8'h00, "ldi_r2_0");
        chk_flags(1'b1, 1'b0, 1'b0, STICKY, "ldi0");
        run_instr(mk(4'hC, 2'd0, 2'd1, 8'h00), 1'b0, 8'h00, 8'h00, "nop");
        chk_reg(2'd0, 8'h11, "nop.r0");
        chk_reg(2'd3, 8'h05, "nop.r3");
        chk_flags(1'b1, 1'b0, 1'b0, STICKY, "nop");

        // Back-to-back with instr_valid held high
        bb[0] = mk(4'h8, 2'd0, 2'd0, 8'h03);
        bb[1] = mk(4'h8, 2'd1, 2'd0, 8'h04);
        bb[2] = mk(4'h0, 2'd0, 2'd1, 8'h00);
        bb[3] = mk(4'h6, 2'd1, 2'd0, 8'h00);
        idx = 0; last = -1; dones = 0; since = 99;
        instr_valid = 1'b1;
        instr       = bb[0];
        for (int c = 0; c < 16; c++) begin
            acc = instr_valid && instr_ready;
            @(negedge clk);
            if (acc) begin
                if (idx > 0) chk("b2b.gap", 32'(c - last), 32'd3);
                last  = c;
                idx++;
                since = 1;
            end else begin
                since++;
            end
            if (done) dones++;
            chk("b2b.op", 32'(alu_op), 32'((since == 1) ? exp_op(bb[idx-1][15:12]) : 4'hF));
            if (acc) begin
                if (idx < 4) instr = bb[idx];
                else instr_valid = 1'b0;
            end
        end
        chk("b2b.accepts", 32'(idx),   32'd4);
        chk("b2b.dones",   32'(dones), 32'd4);
        chk_reg(2'd0, 8'h07, "b2b.r0");
        chk_reg(2'd1, 8'h05, "b2b.r1");
        chk_flags(1'b0, 1'b0, 1'b0, STICKY, "b2b");

        // Sticky overflow survives a clean op and is cleared by CLRV
        run_instr(mk(4'h8, 2'd2, 2'd0, 8'h7F), 1'b0, 8'h00, 8'h00, "ldi_r2_7f");
        run_instr(mk(4'h8, 2'd3, 2'd0, 8'h01), 1'b0, 8'h00, 8'h00, "ldi_r3_1");
        run_instr(mk(4'h0, 2'd2, 2'd3, 8'h00), 1'b1, 8'h7F, 8'h01, "add_ovf");
        chk_flags(1'b0, 1'b0, 1'b1, STICKY, "ovf");
        run_instr(mk(4'h8, 2'd2, 2'd0, 8'h01), 1'b0, 8'h00, 8'h00, "ldi_r2_1");
        run_instr(mk(4'h0, 2'd2, 2'd2, 8'h00), 1'b1, 8'h01, 8'h01, "add_r2r2");
        chk_reg(2'd2, 8'h02, "add11.r2");
        chk_flags(1'b0, 1'b0, 1'b0, STICKY, "add11");
        run_instr(mk(4'hB, 2'd2, 2'd3, 8'h00), 1'b0, 8'h00, 8'h00, "clrv");
        chk_flags(1'b0, 1'b0, 1'b0, 1'b0, "clrv");
        chk_reg(2'd2, 8'h02, "clrv.r2");
        chk_reg(2'd3, 8'h01, "clrv.r3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
